pipe_scheduler: RTL
===================

# pipe_scheduler

Sequencing controller for the pipe-gap ROM. Owns the horizontal scroll of the four-pipe field, selects which gap pattern the ROM presents by driving its 2-bit index, and swaps the pattern each time the whole field scrolls past. It also counts pipes passed (score) and freezes the field on collision. Sits between the frame-tick generator and the VGA renderer / ROM.

## Interface
- PIPE_SPACING, 160: horizontal pixels between adjacent pipes; the field spans 4*PIPE_SPACING.
- SPEED, 2: pixels scrolled per Tick; must satisfy 1 <= SPEED < PIPE_SPACING.
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- Start  in  1  one-cycle pulse; begins or restarts play.
- Tick  in  1  one-cycle scroll strobe, nominally once per frame.
- Collide  in  1  level; bird overlaps a pipe or the ground.
- RomI  out  2  pattern index to the gap ROM.
- ScrollX  out  10  field scroll offset, 0..4*PIPE_SPACING-1.
- Score  out  8  pipes passed, saturating.
- Running  out  1  high in RUN and SWAP.
- PatternLoad  out  1  one-cycle pulse when RomI takes a new value.

## Operation
- States: IDLE, RUN, SWAP, OVER. Reset -> IDLE, RomI=0, ScrollX=0, Score=0, internal phase=0, Running=0, PatternLoad=0.
- IDLE: outputs held. Start -> RUN.
- RUN, Tick: raw = ScrollX+SPEED.
  - raw >= 4*PIPE_SPACING: ScrollX <= raw-4*PIPE_SPACING; go to SWAP.
  - Otherwise ScrollX <= raw.
- Score increments on any Tick where phase+SPEED >= PIPE_SPACING.
  - phase is ScrollX mod PIPE_SPACING, tracked in its own register.
  - The wrap Tick always counts; saturate at 255.
- SWAP: lasts one cycle.
  - RomI <= next index; PatternLoad=1; return to RUN.
  - A Tick arriving in SWAP is dropped.
- Collide in RUN or SWAP -> OVER. Collide wins over a same-cycle Tick, so no scroll or score update occurs.
  - A pending SWAP pattern change is abandoned.
- OVER: ScrollX, RomI, Score frozen; Running=0.
  - Start -> RUN with ScrollX=0, phase=0, Score=0; RomI kept.
- Start is ignored in RUN and SWAP. Collide is ignored in IDLE and OVER.
- Reset asserted in any state, including mid-SWAP, returns everything to reset values the next cycle; PatternLoad is not emitted.

## Timing
- All outputs are registered.
- Tick at cycle n: ScrollX and Score are valid at n+1.
- On a wrap: RomI changes and PatternLoad pulses at n+2.
- Collide at cycle n: Running=0 at n+1.
- Start at cycle n: Running=1 at n+1.

## Configuration
- PIPE_SCHED_LFSR_EN defined:
  - Next RomI comes from an 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5 on Reset, stepping every clock.
  - Next RomI = LFSR[1:0]; if that equals the current RomI, use RomI+1 mod 4 instead.
- PIPE_SCHED_LFSR_EN undefined: next RomI = RomI+1 mod 4 (0,1,2,3,0,...). No LFSR logic is instantiated.

## Structure
- Shared package pipe_sched_pkg holds:
  - state encoding (IDLE=0, RUN=1, SWAP=2, OVER=3)
  - NUM_PIPES=4
  - LFSR_SEED=8'hA5 and the LFSR tap mask
  - SCORE_MAX=255
- One sub-module, pipe_lfsr: 8-bit LFSR with Clk/Reset, output state. Instantiated only under PIPE_SCHED_LFSR_EN.

## Test plan
- Reset, then Start, then 80 Ticks (defaults) -> ScrollX=160, Score=1, RomI=0, no PatternLoad.
- Start, then 320 Ticks, macro off -> after the 320th Tick: ScrollX=0 and Score=4; one cycle later RomI=1 with PatternLoad high for exactly one cycle.
- Collide and Tick in the same cycle during RUN -> ScrollX and Score unchanged, Running=0 next cycle. Further Ticks and Collide have no effect. Start -> ScrollX=0, Score=0, Running=1.
- Score preloaded to 255 by running 20400 Ticks -> Score stays 255 while ScrollX keeps wrapping and RomI keeps rotating.
- Tick held high for 2 cycles at the wrap point -> the second Tick lands in SWAP and is dropped; ScrollX advances by SPEED only once.
- Macro on: 8 consecutive wraps -> RomI never equals its previous value. After Reset the index sequence repeats identically for the same Start timing.

Source files
------------

// File: rtl/pipe_sched_pkg.sv
// Shared types and constants for the pipe-field sequencer and its optional LFSR.
// Optional random pattern order is enabled with `define PIPE_SCHED_LFSR_EN.
package pipe_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SWAP = 2'd2,
        ST_OVER = 2'd3
    } sched_state_t;

    localparam int         NUM_PIPES = 4;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] SCORE_MAX = 8'd255;

    // A random candidate equal to the current pattern is bumped so the field always changes.
    function automatic logic [1:0] pick_next_index(input logic [1:0] cur, input logic [1:0] cand);
        return (cand == cur) ? cur + 2'd1 : cand;
    endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded on reset and stepping every clock.
// Only instantiated when PIPE_SCHED_LFSR_EN is defined.
module pipe_lfsr
    import pipe_sched_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    output logic [7:0] o_state
);

    logic [7:0] r_state;
    logic       w_feedback;

    assign w_feedback = ^(r_state & LFSR_TAPS);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= LFSR_SEED;
        end else begin
            r_state <= {r_state[6:0], w_feedback};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/pipe_scheduler.sv
// Scrolls the four-pipe field, scores pipes passed, swaps the gap-ROM pattern on each
// full-field wrap and freezes on collision. Define PIPE_SCHED_LFSR_EN for random pattern order.
module pipe_scheduler
    import pipe_sched_pkg::*;
#(
    parameter int PIPE_SPACING = 160,
    parameter int SPEED        = 2
)
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_tick,
    input  logic       i_collide,
    output logic [1:0] o_rom_i,
    output logic [9:0] o_scroll_x,
    output logic [7:0] o_score,
    output logic       o_running,
    output logic       o_pattern_load
);

    localparam int         FIELD     = NUM_PIPES * PIPE_SPACING;
    localparam logic [9:0] FIELD_W   = 10'(FIELD);
    localparam logic [9:0] SPACING_W = 10'(PIPE_SPACING);
    localparam logic [9:0] SPEED_W   = 10'(SPEED);

    sched_state_t r_state;
    logic [9:0]   r_scroll_x;
    logic [9:0]   r_phase;
    logic [7:0]   r_score;
    logic [1:0]   r_rom_i;
    logic         r_running;
    logic         r_pattern_load;

    logic [9:0]   w_raw;
    logic [9:0]   w_phase_raw;
    logic         w_wrap;
    logic         w_pass;
    logic [7:0]   w_score_inc;
    logic [1:0]   w_next_idx;

    // Field and phase sums stay below 1024 because SPEED < PIPE_SPACING.
    assign w_raw       = r_scroll_x + SPEED_W;
    assign w_phase_raw = r_phase + SPEED_W;
    assign w_wrap      = (w_raw >= FIELD_W);
    assign w_pass      = (w_phase_raw >= SPACING_W);
    assign w_score_inc = (r_score == SCORE_MAX) ? r_score : r_score + 8'd1;

`ifdef PIPE_SCHED_LFSR_EN
    logic [7:0] w_lfsr;

    pipe_lfsr u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_state (w_lfsr)
    );

    assign w_next_idx = pick_next_index(r_rom_i, w_lfsr[1:0]);
`else
    assign w_next_idx = r_rom_i + 2'd1;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_scroll_x     <= '0;
            r_phase        <= '0;
            r_score        <= '0;
            r_rom_i        <= '0;
            r_running      <= 1'b0;
            r_pattern_load <= 1'b0;
        end else begin
            r_pattern_load <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_collide) begin
                        r_state   <= ST_OVER;
                        r_running <= 1'b0;
                    end else if (i_tick) begin
                        r_scroll_x <= w_wrap ? w_raw - FIELD_W : w_raw;
                        r_phase    <= w_pass ? w_phase_raw - SPACING_W : w_phase_raw;
                        if (w_pass) begin
                            r_score <= w_score_inc;
                        end
                        if (w_wrap) begin
                            r_state <= ST_SWAP;
                        end
                    end
                end
                ST_SWAP: begin
                    // Any tick seen here is dropped; collision abandons the pattern change.
                    if (i_collide) begin
                        r_state   <= ST_OVER;
                        r_running <= 1'b0;
                    end else begin
                        r_rom_i        <= w_next_idx;
                        r_pattern_load <= 1'b1;
                        r_state        <= ST_RUN;
                    end
                end
                ST_OVER: begin
                    if (i_start) begin
                        r_state    <= ST_RUN;
                        r_running  <= 1'b1;
                        r_scroll_x <= '0;
                        r_phase    <= '0;
                        r_score    <= '0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign o_rom_i        = r_rom_i;
    assign o_scroll_x     = r_scroll_x;
    assign o_score        = r_score;
    assign o_running      = r_running;
    assign o_pattern_load = r_pattern_load;

endmodule
